// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM states, PC step, reset vector and
// the instruction/PC pair that also travels into decode.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] FETCH_STEP       = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_pair_t;

endpackage

// File: rtl/inst_queue.sv
// Two-entry shift FIFO of instruction/PC pairs. The head entry sits in its own
// register so the outputs toward decode come straight from flops.
module inst_queue
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fetch_pair_t push_data,
    input  logic        pop,
    input  logic        flush,
    output fetch_pair_t head,
    output logic        head_valid,
    output logic [1:0]  occupancy
);

    fetch_pair_t head_reg;
    fetch_pair_t tail_reg;
    logic        head_valid_reg;
    logic        tail_valid_reg;
    logic        do_pop;

    assign do_pop = pop && head_valid_reg;

    // The tail is only ever occupied while the head is, so a pop shifts tail to head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            head_valid_reg <= 1'b0;
            tail_valid_reg <= 1'b0;
        end else if (flush) begin
            head_valid_reg <= 1'b0;
            tail_valid_reg <= 1'b0;
        end else if (do_pop) begin
            if (tail_valid_reg) begin
                head_reg <= tail_reg;
                if (push) begin
                    tail_reg <= push_data;
                end else begin
                    tail_valid_reg <= 1'b0;
                end
            end else if (push) begin
                head_reg <= push_data;
            end else begin
                head_valid_reg <= 1'b0;
            end
        end else if (push) begin
            if (!head_valid_reg) begin
                head_reg       <= push_data;
                head_valid_reg <= 1'b1;
            end else begin
                tail_reg       <= push_data;
                tail_valid_reg <= 1'b1;
            end
        end
    end

    assign head       = head_reg;
    assign head_valid = head_valid_reg;
    assign occupancy  = {head_valid_reg & tail_valid_reg, head_valid_reg ^ tail_valid_reg};

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one ROM read per instruction through the controller,
// completion qualified by a guard window, results queued toward decode.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          MIN_WAIT = 6
) (
    input  logic        clk,
    input  logic        rst,
    output logic        read_ce,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_fin,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int CNT_W = $clog2(MIN_WAIT + 2);

    fetch_state_t     state_reg;
    logic [31:0]      pc_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             read_ce_reg;
    logic [31:0]      mem_addr_reg;

    logic             complete;
    logic             push;
    logic [1:0]       occupancy;
    fetch_pair_t      push_data;
    fetch_pair_t      head;

    // mem_fin stays high from the previous access, so only the guard window qualifies it.
    assign complete  = (state_reg == REQ) && mem_fin && (wait_cnt_reg >= CNT_W'(MIN_WAIT));
    assign push      = complete && !redirect;
    assign push_data = '{inst: mem_data, pc: mem_addr_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            wait_cnt_reg <= '0;
            read_ce_reg  <= 1'b0;
            mem_addr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (redirect) begin
                        pc_reg <= redirect_pc;
                    end else if (!occupancy[1]) begin
                        // Occupancy below two guarantees room when this read completes.
                        state_reg    <= REQ;
                        mem_addr_reg <= pc_reg;
                        read_ce_reg  <= 1'b1;
                        wait_cnt_reg <= '0;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        pc_reg      <= redirect_pc;
                        read_ce_reg <= 1'b0;
                        state_reg   <= GAP;
                    end else if (complete) begin
                        pc_reg      <= pc_reg + FETCH_STEP;
                        read_ce_reg <= 1'b0;
                        state_reg   <= GAP;
                    end else if (wait_cnt_reg < CNT_W'(MIN_WAIT)) begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (redirect) begin
                        pc_reg <= redirect_pc;
                    end
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg   <= IDLE;
                    read_ce_reg <= 1'b0;
                end
            endcase
        end
    end

    inst_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (inst_ready),
        .flush      (redirect),
        .head       (head),
        .head_valid (inst_valid),
        .occupancy  (occupancy)
    );

    assign read_ce  = read_ce_reg;
    assign mem_addr = mem_addr_reg;
    assign inst     = head.inst;
    assign inst_pc  = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios pinned with literals,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam int          MIN_WAIT = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_ce;
    logic [31:0] mem_addr;
    logic [31:0] mem_data = '0;
    logic        mem_fin = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RESET_PC), .MIN_WAIT(MIN_WAIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .read_ce     (read_ce),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_fin     (mem_fin),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    // Model: access progress counted in read_ce-high cycles, gap length counted
    // in read_ce-low cycles, and the instruction queue as a plain SV queue.
    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } pair_t;

    pair_t       m_q[$];
    logic        m_rce;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    int          m_k;
    int          m_low;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rce  = 1'b0;
        m_addr = '0;
        m_pc   = RESET_PC;
        m_k    = 0;
        m_low  = 2;
    endtask

    task automatic model_edge(input logic rd, input logic [31:0] rpc, input logic rdy,
                              input logic fin, input logic [31:0] data);
        int occ;
        occ = m_q.size();
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (m_rce) begin
            if (rd) begin
                m_rce = 1'b0;
                m_low = 1;
            end else if (fin && m_k >= MIN_WAIT + 1) begin
                m_q.push_back('{word: data, pc: m_addr});
                m_pc  = m_pc + 32'd4;
                m_rce = 1'b0;
                m_low = 1;
            end else begin
                m_k++;
            end
        end else begin
            if (!rd && m_low >= 2 && occ < 2) begin
                m_rce  = 1'b1;
                m_addr = m_pc;
                m_k    = 1;
            end else if (m_low < 2) begin
                m_low++;
            end
        end
        if (rd) begin
            m_q.delete();
            m_pc = rpc;
        end
    endtask

    task automatic compare_all();
        chk("read_ce", {31'd0, read_ce}, {31'd0, m_rce});
        if (m_rce) chk("mem_addr", mem_addr, m_addr);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, (m_q.size() > 0)});
        if (m_q.size() > 0) begin
            chk("inst", inst, m_q[0].word);
            chk("inst_pc", inst_pc, m_q[0].pc);
        end
    endtask

    // Called at a negedge: drive inputs for the coming edge, advance the model,
    // then compare at the following negedge.
    task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rdy,
                         input logic fin, input logic [31:0] data);
        redirect    = rd;
        redirect_pc = rpc;
        inst_ready  = rdy;
        mem_fin     = fin;
        mem_data    = data;
        model_edge(rd, rpc, rdy, fin, data);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        $display("cyc t=%0t rd=%0b rdy=%0b fin=%0b | read_ce=%0b addr=%h valid=%0b inst=%h pc=%h",
                 $time, rd, rdy, fin, read_ce, mem_addr, inst_valid, inst, inst_pc);
    endtask

    initial begin
        int rp;
        int guard;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read_ce", {31'd0, read_ce}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        rst = 1'b0;

        // Reset fetch with mem_fin stale-high from the start
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0BAD_0000);
        chk("first_read_ce", {31'd0, read_ce}, 32'd1);
        chk("first_addr", mem_addr, 32'hBFC0_0000);
        for (int k = 1; k <= 7; k++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, (k == 7) ? 32'h3C08_0001 : (32'h0BAD_0000 + k));
            if (k < 7) chk("no_early_push", {31'd0, inst_valid}, 32'd0);
        end
        chk("rf_valid", {31'd0, inst_valid}, 32'd1);
        chk("rf_inst", inst, 32'h3C08_0001);
        chk("rf_pc", inst_pc, 32'hBFC0_0000);
        chk("rf_gap", {31'd0, read_ce}, 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
        chk("rf_idle", {31'd0, read_ce}, 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
        chk("rf_next_ce", {31'd0, read_ce}, 32'd1);
        chk("rf_next_addr", mem_addr, 32'hBFC0_0004);

        // Backpressure: second completion fills the queue, no third launch
        for (int k = 1; k <= 7; k++) cycle(1'b0, '0, 1'b0, 1'b1, 32'h1111_0004);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
            chk("bp_no_launch", {31'd0, read_ce}, 32'd0);
        end
        chk("bp_head_pc", inst_pc, 32'hBFC0_0000);
        cycle(1'b0, '0, 1'b1, 1'b1, 32'h0);
        chk("bp_pop_pc", inst_pc, 32'hBFC0_0004);
        chk("bp_pop_inst", inst, 32'h1111_0004);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
        chk("bp_relaunch", {31'd0, read_ce}, 32'd1);
        chk("bp_relaunch_addr", mem_addr, 32'hBFC0_0008);

        // Redirect at wait cycle 3
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 32'h8000_0100, 1'b0, 1'b1, 32'h0);
        chk("rd_ce_drop", {31'd0, read_ce}, 32'd0);
        chk("rd_flush", {31'd0, inst_valid}, 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
        chk("rd_idle", {31'd0, read_ce}, 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
        chk("rd_relaunch", {31'd0, read_ce}, 32'd1);
        chk("rd_addr", mem_addr, 32'h8000_0100);

        // Redirect, pop and completion all in one cycle
        for (int k = 1; k <= 7; k++) cycle(1'b0, '0, 1'b0, 1'b1, 32'hAAAA_0000);
        chk("sim_head", inst_pc, 32'h8000_0100);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
        chk("sim_launch_addr", mem_addr, 32'h8000_0104);
        for (int k = 1; k <= 6; k++) cycle(1'b0, '0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'h8000_0200, 1'b1, 1'b1, 32'hBBBB_0000);
        chk("sim_empty", {31'd0, inst_valid}, 32'd0);
        chk("sim_ce", {31'd0, read_ce}, 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
        chk("sim_relaunch_addr", mem_addr, 32'h8000_0200);

        // Randomized traffic, ready probability changed per block
        for (int b = 0; b < 15; b++) begin
            rp = (b % 4 == 3) ? 0 : $urandom_range(20, 100);
            for (int i = 0; i < 200; i++) begin
                cycle(($urandom_range(0, 39) == 0), $urandom() & 32'hFFFF_FFFC,
                      ($urandom_range(0, 99) < rp), ($urandom_range(0, 2) != 0), $urandom());
            end
        end

        // Async reset in the middle of an access with a valid head
        guard = 0;
        while (!(m_rce && m_q.size() == 1) && guard < 200) begin
            cycle(1'b0, '0, (m_q.size() == 2), 1'b1, $urandom());
            guard++;
        end
        chk("ar_setup_timeout", (guard < 200) ? 32'd1 : 32'd0, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_read_ce", {31'd0, read_ce}, 32'd0);
        chk("ar_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("ar_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h0);
        chk("ar_relaunch", {31'd0, read_ce}, 32'd1);
        chk("ar_reset_pc", mem_addr, 32'hBFC0_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
